// File: rtl/mips_defs.sv
// Shared MIPS definitions: memory opcodes, decoded memory-op enum,
// and data-memory size defaults.
package mips_defs;

    localparam int DM_DEPTH = 3072;
    localparam int DM_AW    = 12;

    localparam logic [5:0] OPC_SW  = 6'b101011;
    localparam logic [5:0] OPC_SH  = 6'b101001;
    localparam logic [5:0] OPC_SB  = 6'b101000;
    localparam logic [5:0] OPC_LW  = 6'b100011;
    localparam logic [5:0] OPC_LH  = 6'b100001;
    localparam logic [5:0] OPC_LHU = 6'b100101;
    localparam logic [5:0] OPC_LB  = 6'b100000;
    localparam logic [5:0] OPC_LBU = 6'b100100;

    typedef enum logic [3:0] {
        MOP_NONE,
        MOP_SW,
        MOP_SH,
        MOP_SB,
        MOP_LW,
        MOP_LH,
        MOP_LHU,
        MOP_LB,
        MOP_LBU
    } mem_op_t;

    function automatic mem_op_t decode_mem_op(
        input logic [5:0] opc
    );
        mem_op_t op;
        case (opc)
            OPC_SW:  op = MOP_SW;
            OPC_SH:  op = MOP_SH;
            OPC_SB:  op = MOP_SB;
            OPC_LW:  op = MOP_LW;
            OPC_LH:  op = MOP_LH;
            OPC_LHU: op = MOP_LHU;
            OPC_LB:  op = MOP_LB;
            OPC_LBU: op = MOP_LBU;
            default: op = MOP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/m_stage_dm_lane_unit.sv
// dm_lane_unit: merges store data into the addressed word and
// extracts/extends load data. Ports: old_word, store_data, lane, op
// in; merged, load_val, wr_ok (aligned store) out.
module dm_lane_unit
    import mips_defs::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    input  logic [1:0]  lane,
    input  mem_op_t     op,
    output logic [31:0] merged,
    output logic [31:0] load_val,
    output logic        wr_ok
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    assign half_v = lane[1] ? old_word[31:16]
                            : old_word[15:0];
    assign byte_v = old_word[{lane, 3'b000} +: 8];

    always_comb begin
        merged   = old_word;
        load_val = '0;
        wr_ok    = 1'b0;
        unique case (op)
            MOP_SW: begin
                wr_ok  = (lane == 2'b00);
                merged = store_data;
            end
            MOP_SH: begin
                wr_ok = ~lane[0];
                merged[{lane[1], 4'b0000} +: 16] =
                    store_data[15:0];
            end
            MOP_SB: begin
                wr_ok = 1'b1;
                merged[{lane, 3'b000} +: 8] =
                    store_data[7:0];
            end
            MOP_LW: begin
                if (lane == 2'b00)
                    load_val = old_word;
            end
            MOP_LH: begin
                if (!lane[0])
                    load_val = {{16{half_v[15]}}, half_v};
            end
            MOP_LHU: begin
                if (!lane[0])
                    load_val = {16'h0, half_v};
            end
            MOP_LB:
                load_val = {{24{byte_v[7]}}, byte_v};
            MOP_LBU:
                load_val = {24'h0, byte_v};
            default: ;
        endcase
    end

endmodule

// File: rtl/m_stage_dm.sv
// M-stage data memory: word/half/byte loads and stores with W-stage
// store-data forwarding. Ports: clk, reset, M_Instr, M_PC,
// M_ALUResult, M_RD2, W_RegWrite/W_RegAddr/W_WriteData in;
// M_MemReadData (extended load), M_StoreData (forwarded) out.
module m_stage_dm
    import mips_defs::*;
#(
    parameter int DEPTH = DM_DEPTH,
    parameter int AW    = DM_AW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_Instr,
    input  logic [31:0] M_PC,
    input  logic [31:0] M_ALUResult,
    input  logic [31:0] M_RD2,
    input  logic        W_RegWrite,
    input  logic [4:0]  W_RegAddr,
    input  logic [31:0] W_WriteData,
    output logic [31:0] M_MemReadData,
    output logic [31:0] M_StoreData
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [31:0] mem [DEPTH];

    mem_op_t     op;
    logic [AW-1:0] idx;
    logic [1:0]  lane;
    logic [4:0]  rt;
    logic        hi_zero;
    logic        in_range;
    logic [31:0] word_q;
    logic [31:0] merged;
    logic [31:0] load_val;
    logic        wr_ok;
    logic        we;
    logic        unused_bits;

    assign op   = decode_mem_op(M_Instr[31:26]);
    assign rt   = M_Instr[20:16];
    assign idx  = M_ALUResult[AW+1:2];
    assign lane = M_ALUResult[1:0];

    // Address bits above the word index must be zero, and the
    // index itself must fall inside a non power-of-two array.
    assign hi_zero  = (M_ALUResult >> (AW+2)) == 32'd0;
    assign in_range = hi_zero && ({1'b0, idx} < DEPTH_L);

    assign M_StoreData =
        (W_RegWrite && W_RegAddr != 5'd0 && W_RegAddr == rt)
            ? W_WriteData : M_RD2;

    assign word_q = in_range ? mem[idx] : '0;

    dm_lane_unit u_lane (
        .old_word   (word_q),
        .store_data (M_StoreData),
        .lane       (lane),
        .op         (op),
        .merged     (merged),
        .load_val   (load_val),
        .wr_ok      (wr_ok)
    );

    assign we = wr_ok && in_range;

    assign M_MemReadData = in_range ? load_val : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (we) begin
            mem[idx] <= merged;
        end
    end

    assign unused_bits = ^{M_Instr[25:21], M_Instr[15:0]};

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && we)
            $display("%d@%h: *%h <= %h", $time, M_PC,
                     {M_ALUResult[31:2], 2'b00}, merged);
    end
`endif

endmodule
